// File: rtl/qpl_dealloc_sched_if.sv
// Port bundle for qpl_dealloc_sched: requester, compressor and allocator channels.
// o_err is present only when QPL_DEALLOC_CHECK_EN is defined.
interface qpl_dealloc_sched_if #(
    parameter int BITMAP = 256,
    parameter int REQS   = 4
);
    localparam int BLOCK_W = $clog2(BITMAP);
    localparam int SCB_W   = (BITMAP / 2) * $clog2(BITMAP);

    logic [REQS-1:0]             i_req_vld;
    logic [REQS*BLOCK_W-1:0]     i_req_addr;
    logic [REQS*(BLOCK_W+1)-1:0] i_req_size;
    logic [REQS-1:0]             o_req_rdy;
    logic [REQS-1:0]             o_done;
    logic                        o_cmp_vld;
    logic [BLOCK_W-1:0]          o_cmp_addr;
    logic [BLOCK_W:0]            o_cmp_size;
    logic [SCB_W-1:0]            o_cmp_scb;
    logic                        i_cmp_vld;
    logic [SCB_W-1:0]            i_cmp_scb;
    logic                        i_alloc_wr;
    logic [SCB_W-1:0]            i_alloc_scb;
    logic                        o_alloc_rdy;
    logic [SCB_W-1:0]            o_scb;
    logic                        o_busy;
`ifdef QPL_DEALLOC_CHECK_EN
    logic                        o_err;
`endif

    modport slave (
        input  i_req_vld, i_req_addr, i_req_size, i_cmp_vld, i_cmp_scb,
        input  i_alloc_wr, i_alloc_scb,
        output o_req_rdy, o_done, o_cmp_vld, o_cmp_addr, o_cmp_size, o_cmp_scb,
        output o_alloc_rdy, o_scb, o_busy
`ifdef QPL_DEALLOC_CHECK_EN
        , output o_err
`endif
    );

    modport master (
        output i_req_vld, i_req_addr, i_req_size, i_cmp_vld, i_cmp_scb,
        output i_alloc_wr, i_alloc_scb,
        input  o_req_rdy, o_done, o_cmp_vld, o_cmp_addr, o_cmp_size, o_cmp_scb,
        input  o_alloc_rdy, o_scb, o_busy
`ifdef QPL_DEALLOC_CHECK_EN
        , input o_err
`endif
    );
endinterface

// File: rtl/qpl_dealloc_sched.sv
// SCB register owner and round-robin deallocation scheduler for the QuickPageLite compressor.
// Optional range check on granted requests: define QPL_DEALLOC_CHECK_EN (adds o_err).
module qpl_dealloc_sched #(
    parameter int BITMAP = 256,
    parameter int REQS   = 4
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    qpl_dealloc_sched_if.slave   bus
);
    localparam int BLOCK_W = $clog2(BITMAP);
    localparam int SCB_W   = (BITMAP / 2) * $clog2(BITMAP);
    localparam int RR_W    = $clog2(REQS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [SCB_W-1:0]   scb_r, scb_s;
    logic [RR_W-1:0]    rr_r, rr_s;
    logic [RR_W-1:0]    g_r, g_s;
    logic [BLOCK_W-1:0] addr_r, addr_s;
    logic [BLOCK_W:0]   size_r, size_s;
    logic [RR_W-1:0]    win_s;
    logic               found_s;
    int                 scan_idx_s;
    logic [BLOCK_W-1:0] sel_addr_s;
    logic [BLOCK_W:0]   sel_size_s;
    logic [REQS-1:0]    req_rdy_s;
    logic [REQS-1:0]    done_s;
`ifdef QPL_DEALLOC_CHECK_EN
    localparam int      SUM_W = BLOCK_W + 2;
    logic               err_r, err_s;
    logic               range_err_s;
    logic [SUM_W-1:0]   range_end_s;
`endif

    // Round-robin winner: scanning downward in offset leaves the lowest offset from rr_r.
    always_comb begin
        found_s    = 1'b0;
        win_s      = '0;
        scan_idx_s = 0;
        for (int i = REQS - 1; i >= 0; i--) begin
            scan_idx_s = (int'(rr_r) + i >= REQS) ? int'(rr_r) + i - REQS : int'(rr_r) + i;
            win_s      = bus.i_req_vld[scan_idx_s] ? RR_W'(scan_idx_s) : win_s;
            found_s    = found_s | bus.i_req_vld[scan_idx_s];
        end
    end

    // Payload of the winning requester.
    always_comb begin
        sel_addr_s = '0;
        sel_size_s = '0;
        for (int k = 0; k < REQS; k++) begin
            sel_addr_s = (win_s == RR_W'(k)) ? bus.i_req_addr[k*BLOCK_W +: BLOCK_W] : sel_addr_s;
            sel_size_s = (win_s == RR_W'(k)) ? bus.i_req_size[k*(BLOCK_W+1) +: BLOCK_W+1] : sel_size_s;
        end
    end

`ifdef QPL_DEALLOC_CHECK_EN
    // Range check at BLOCK_W+2 bits so addr+size cannot wrap.
    always_comb begin
        range_end_s = {2'b00, sel_addr_s} + {1'b0, sel_size_s};
        range_err_s = (sel_size_s == '0) || (range_end_s > SUM_W'(BITMAP));
    end
`endif

    // Next-state and handshake decode; allocator wins over deallocation in IDLE.
    always_comb begin
        state_s   = state_r;
        scb_s     = scb_r;
        rr_s      = rr_r;
        g_s       = g_r;
        addr_s    = addr_r;
        size_s    = size_r;
        req_rdy_s = '0;
        done_s    = '0;
`ifdef QPL_DEALLOC_CHECK_EN
        err_s     = err_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.i_alloc_wr) begin
                    scb_s = bus.i_alloc_scb;
                end else if (found_s) begin
                    req_rdy_s[win_s] = 1'b1;
                    g_s              = win_s;
                    addr_s           = sel_addr_s;
                    size_s           = sel_size_s;
`ifdef QPL_DEALLOC_CHECK_EN
                    err_s            = range_err_s;
                    if (range_err_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = ISSUE;
                    end
`else
                    state_s          = ISSUE;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (bus.i_cmp_vld) begin
                    scb_s   = bus.i_cmp_scb;
                    state_s = DONE;
                end else begin
                    state_s = ISSUE;
                end
            end
            DONE: begin
                done_s[g_r] = 1'b1;
                rr_s        = (g_r == RR_W'(REQS - 1)) ? '0 : g_r + 1'b1;
                state_s     = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, SCB and captured-request registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            scb_r   <= '0;
            rr_r    <= '0;
            g_r     <= '0;
            addr_r  <= '0;
            size_r  <= '0;
`ifdef QPL_DEALLOC_CHECK_EN
            err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            scb_r   <= scb_s;
            rr_r    <= rr_s;
            g_r     <= g_s;
            addr_r  <= addr_s;
            size_r  <= size_s;
`ifdef QPL_DEALLOC_CHECK_EN
            err_r   <= err_s;
`endif
        end
    end

    assign bus.o_req_rdy   = req_rdy_s;
    assign bus.o_done      = done_s;
    assign bus.o_cmp_vld   = (state_r == ISSUE);
    assign bus.o_cmp_addr  = (state_r == ISSUE) ? addr_r : '0;
    assign bus.o_cmp_size  = (state_r == ISSUE) ? size_r : '0;
    assign bus.o_cmp_scb   = scb_r;
    assign bus.o_scb       = scb_r;
    assign bus.o_alloc_rdy = (state_r == IDLE);
    assign bus.o_busy      = (state_r != IDLE);
`ifdef QPL_DEALLOC_CHECK_EN
    assign bus.o_err       = (state_r == DONE) && err_r;
`endif
endmodule

// File: tb/tb_qpl_dealloc_sched.sv
// Randomized scoreboard bench for qpl_dealloc_sched against a transaction-level model.
module tb_qpl_dealloc_sched;
    localparam int BITMAP  = 256;
    localparam int REQS    = 4;
    localparam int SCB_W   = 1024;
    localparam int CYCLES  = 900;

    logic clk;
    logic rst_n;

    qpl_dealloc_sched_if #(.BITMAP(BITMAP), .REQS(REQS)) bus ();
    qpl_dealloc_sched #(.BITMAP(BITMAP), .REQS(REQS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SCB_W-1:0] scb;
        logic             busy;
        logic             alloc_rdy;
        logic             cmp_vld;
        logic             err;
        logic [REQS-1:0]  req_rdy;
        logic [REQS-1:0]  done;
    } cyc_t;

    typedef struct {
        int               g;
        logic [7:0]       addr;
        logic [8:0]       size;
        logic [SCB_W-1:0] scb;
    } txn_t;

    cyc_t cyc_q[$];
    txn_t txn_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    // Model: 0 = free, 1 = waiting on compressor, 2 = reporting completion.
    int               m_stage, m_wait, m_g, m_rr, n_txn;
    bit               m_err;
    logic [SCB_W-1:0] m_scb, m_cmp_scb;
    bit               pend[REQS];
    logic [7:0]       p_addr[REQS];
    logic [8:0]       p_size[REQS];

    function automatic logic [SCB_W-1:0] rand_scb();
        logic [SCB_W-1:0] v;
        for (int i = 0; i < SCB_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [63:0] fold(input logic [SCB_W-1:0] v);
        logic [63:0] f;
        f = 64'd0;
        for (int i = 0; i < SCB_W / 64; i++) f = f ^ v[i*64 +: 64];
        return f;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic check_scb(input string nm, input logic [SCB_W-1:0] act, input logic [SCB_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got digest %h, want digest %h (t=%0t)", nm, fold(act), fold(exp), $time);
    endtask

    function automatic logic [8:0] pick_size(input logic [7:0] addr);
        int r;
        r = $urandom_range(9, 0);
        if (r == 0) return 9'd0;
        if (r == 1) return 9'(BITMAP - int'(addr) + 1);
        return 9'($urandom_range(BITMAP - int'(addr), 1));
    endfunction

    // Drive one cycle of inputs from the bench's own view of the transaction in flight.
    task automatic drive(input int arm_pct, input int alloc_pct);
        for (int k = 0; k < REQS; k++) begin
            if (!pend[k] && $urandom_range(99, 0) < arm_pct) begin
                pend[k]   = 1'b1;
                p_addr[k] = 8'($urandom);
                p_size[k] = pick_size(p_addr[k]);
            end
            bus.i_req_vld[k]          = pend[k];
            bus.i_req_addr[k*8 +: 8]  = p_addr[k];
            bus.i_req_size[k*9 +: 9]  = p_size[k];
        end
        bus.i_alloc_wr  = ($urandom_range(99, 0) < alloc_pct);
        bus.i_alloc_scb = rand_scb();
        if (m_stage == 1) begin
            bus.i_cmp_vld = (m_wait == 0);
            bus.i_cmp_scb = m_cmp_scb;
        end else begin
            bus.i_cmp_vld = ($urandom_range(3, 0) == 0);
            bus.i_cmp_scb = rand_scb();
        end
    endtask

    // Advance the model by one cycle and queue what the DUT must show in it.
    task automatic step_model(input bit fast);
        cyc_t r;
        txn_t t;
        int   g;
        r.scb       = m_scb;
        r.busy      = (m_stage != 0);
        r.alloc_rdy = (m_stage == 0);
        r.cmp_vld   = (m_stage == 1);
        r.err       = 1'b0;
        r.req_rdy   = '0;
        r.done      = '0;
        if (m_stage == 0) begin
            if (bus.i_alloc_wr) begin
                m_scb = bus.i_alloc_scb;
            end else begin
                g = -1;
                for (int j = 0; j < REQS; j++) begin
                    if (g < 0 && pend[(m_rr + j) % REQS]) g = (m_rr + j) % REQS;
                end
                if (g >= 0) begin
                    r.req_rdy[g] = 1'b1;
                    t.g    = g;
                    t.addr = p_addr[g];
                    t.size = p_size[g];
`ifdef QPL_DEALLOC_CHECK_EN
                    m_err = (p_size[g] == 9'd0) || (int'(p_addr[g]) + int'(p_size[g]) > BITMAP);
`else
                    m_err = 1'b0;
`endif
                    if (m_err) begin
                        t.scb   = m_scb;
                        m_stage = 2;
                    end else begin
                        t.scb     = rand_scb();
                        m_cmp_scb = t.scb;
                        m_wait    = fast ? 0 : ((n_txn % 5 == 2) ? 5 : int'($urandom_range(2, 0)));
                        m_stage   = 1;
                    end
                    txn_q.push_back(t);
                    pend[g] = 1'b0;
                    m_g     = g;
                    n_txn++;
                end
            end
        end else if (m_stage == 1) begin
            if (m_wait == 0) begin
                m_scb   = m_cmp_scb;
                m_stage = 2;
            end else begin
                m_wait--;
            end
        end else begin
            r.done[m_g] = 1'b1;
            r.err       = m_err;
            m_rr        = (m_g + 1) % REQS;
            m_stage     = 0;
        end
        cyc_q.push_back(r);
    endtask

    // Monitor: compares per-cycle status and pops transactions as the DUT presents them.
    initial begin
        cyc_t r;
        txn_t t;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("cyc_queue_nonempty", 64'(cyc_q.size() != 0), 64'd1);
                if (cyc_q.size() != 0) begin
                    r = cyc_q.pop_front();
                    check_scb("o_scb", bus.o_scb, r.scb);
                    check_scb("o_cmp_scb", bus.o_cmp_scb, r.scb);
                    check("o_busy", 64'(bus.o_busy), 64'(r.busy));
                    check("o_alloc_rdy", 64'(bus.o_alloc_rdy), 64'(r.alloc_rdy));
                    check("o_cmp_vld", 64'(bus.o_cmp_vld), 64'(r.cmp_vld));
                    check("o_req_rdy", 64'(bus.o_req_rdy), 64'(r.req_rdy));
                    check("o_done", 64'(bus.o_done), 64'(r.done));
`ifdef QPL_DEALLOC_CHECK_EN
                    check("o_err", 64'(bus.o_err), 64'(r.err));
`endif
                end
                if (bus.o_cmp_vld) begin
                    check("txn_pending_at_cmp", 64'(txn_q.size() != 0), 64'd1);
                    if (txn_q.size() != 0) begin
                        check("o_cmp_addr", 64'(bus.o_cmp_addr), 64'(txn_q[0].addr));
                        check("o_cmp_size", 64'(bus.o_cmp_size), 64'(txn_q[0].size));
                    end
                end
                if (bus.o_done != '0) begin
                    check("txn_pending_at_done", 64'(txn_q.size() != 0), 64'd1);
                    if (txn_q.size() != 0) begin
                        t = txn_q.pop_front();
                        check("done_requester", 64'(bus.o_done), 64'(4'b0001 << t.g));
                        check_scb("scb_at_done", bus.o_scb, t.scb);
                    end
                end
            end
        end
    end

    initial begin
        logic [SCB_W-1:0] pat_b;
        logic [REQS-1:0]  done_seen;
        bit               idle_seen;
        rst_n           = 1'b0;
        bus.i_req_vld   = '0;
        bus.i_req_addr  = '0;
        bus.i_req_size  = '0;
        bus.i_cmp_vld   = 1'b0;
        bus.i_cmp_scb   = '0;
        bus.i_alloc_wr  = 1'b0;
        bus.i_alloc_scb = '0;
        m_stage = 0; m_wait = 0; m_g = 0; m_rr = 0; n_txn = 0; m_err = 1'b0;
        m_scb = '0; m_cmp_scb = '0;
        for (int k = 0; k < REQS; k++) begin
            pend[k] = 1'b0; p_addr[k] = 8'd0; p_size[k] = 9'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_scb("reset_scb", bus.o_scb, '0);
        check("reset_busy", 64'(bus.o_busy), 64'd0);
        check("reset_alloc_rdy", 64'(bus.o_alloc_rdy), 64'd1);
        check("reset_req_rdy", 64'(bus.o_req_rdy), 64'd0);
        check("reset_done", 64'(bus.o_done), 64'd0);
        check("reset_cmp_vld", 64'(bus.o_cmp_vld), 64'd0);

        // First 40 cycles: every requester always valid, instant compressor.
        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            #1;
            drive((c < 40) ? 100 : 25, (c < 40) ? 0 : 15);
            step_model(c < 40);
            mon_en = 1'b1;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("cyc_queue_drained", 64'(cyc_q.size()), 64'd0);

        // Drain any in-flight request, then reset in the middle of an ISSUE.
        bus.i_req_vld  = '0;
        bus.i_alloc_wr = 1'b0;
        bus.i_cmp_vld  = 1'b1;
        idle_seen      = 1'b0;
        for (int w = 0; w < 20 && !idle_seen; w++) begin
            @(negedge clk);
            idle_seen = !bus.o_busy;
        end
        check("drain_to_idle", 64'(idle_seen), 64'd1);
        @(posedge clk);
        #1;
        bus.i_cmp_vld   = 1'b0;
        pat_b           = rand_scb();
        bus.i_alloc_wr  = 1'b1;
        bus.i_alloc_scb = pat_b;
        @(posedge clk);
        #1;
        bus.i_alloc_wr = 1'b0;
        check_scb("alloc_write_b", bus.o_scb, pat_b);
        bus.i_req_vld       = 4'b0001;
        bus.i_req_addr[7:0] = 8'h10;
        bus.i_req_size[8:0] = 9'd16;
        @(negedge clk);
        check("direct_grant_rdy", 64'(bus.o_req_rdy), 64'h1);
        @(posedge clk);
        #1;
        bus.i_req_vld = '0;
        check("direct_cmp_vld", 64'(bus.o_cmp_vld), 64'd1);
        check("direct_cmp_addr", 64'(bus.o_cmp_addr), 64'h10);
        check("direct_cmp_size", 64'(bus.o_cmp_size), 64'd16);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_cmp_vld", 64'(bus.o_cmp_vld), 64'd0);
        check("midreset_busy", 64'(bus.o_busy), 64'd0);
        check_scb("midreset_scb", bus.o_scb, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        done_seen = '0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            done_seen = done_seen | bus.o_done;
        end
        check("midreset_no_done", 64'(done_seen), 64'd0);
        check("midreset_alloc_rdy", 64'(bus.o_alloc_rdy), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
